// File: rtl/cpt_bin_mod.sv
// cpt_bin_mod: synchronous up/down modulo counter with terminal count and sticky wrap flag.
// Define CPT_BIN_LOAD_EN to enable the clamped parallel load.
module cpt_bin_mod #(
  parameter int WIDTH = 8,
  parameter longint unsigned MODULO = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 64'd1);
  logic wrap;
  assign wrap = up ? (out == MAX) : (out == '0);
`ifdef CPT_BIN_LOAD_EN
  assign tc = activate & ~load & wrap;
`else
  logic unused;
  assign unused = ^{load, load_val};
  assign tc = activate & wrap;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= '0;
      ovf <= 1'b0;
    end
`ifdef CPT_BIN_LOAD_EN
    else if (load) begin
      out <= load_val > MAX ? MAX : load_val;
      ovf <= 1'b0;
    end
`endif
    else if (activate) begin
      out <= up ? (wrap ? '0 : out + WIDTH'(1)) : (wrap ? MAX : out - WIDTH'(1));
      ovf <= ovf | wrap;
    end
  end
endmodule

// File: tb/tb_cpt_bin_mod.sv
// tb_cpt_bin_mod: table-driven check of the modulo-10 counter plus cascade and full-width sequences.
module tb_cpt_bin_mod;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic act = 1'b0, up = 1'b1, ld = 1'b0;
  logic [3:0] lv = 4'd0;
  logic [3:0] out;
  logic tc, ovf;
  cpt_bin_mod #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .reset(reset), .activate(act), .up(up), .load(ld), .load_val(lv),
    .out(out), .tc(tc), .ovf(ovf));
  logic cact = 1'b0;
  logic [3:0] c0_out, c1_out;
  logic c0_tc, c1_tc, c0_ovf, c1_ovf;
  cpt_bin_mod #(.WIDTH(4), .MODULO(10)) u_c0 (
    .clk(clk), .reset(reset), .activate(cact), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .out(c0_out), .tc(c0_tc), .ovf(c0_ovf));
  cpt_bin_mod #(.WIDTH(4), .MODULO(10)) u_c1 (
    .clk(clk), .reset(reset), .activate(c0_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .out(c1_out), .tc(c1_tc), .ovf(c1_ovf));
  logic fact = 1'b0;
  logic [2:0] f_out;
  logic f_tc, f_ovf;
  cpt_bin_mod #(.WIDTH(3), .MODULO(8)) u_f (
    .clk(clk), .reset(reset), .activate(fact), .up(1'b1), .load(1'b0), .load_val(3'd0),
    .out(f_out), .tc(f_tc), .ovf(f_ovf));
  typedef struct {
    logic act, up, ld;
    logic [3:0] lv;
    logic etc;
    logic [3:0] eout;
    logic eovf;
  } vec_t;
  vec_t vq[$];
  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, got, exp);
  endtask
  task automatic add(input logic a, input logic u, input logic l, input logic [3:0] v,
                     input logic t, input logic [3:0] o, input logic f);
    vec_t e;
    e.act = a; e.up = u; e.ld = l; e.lv = v; e.etc = t; e.eout = o; e.eovf = f;
    vq.push_back(e);
  endtask
  // tc is checked before the edge with the new inputs; out/ovf after it
  task automatic run_q();
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      act = vq[i].act; up = vq[i].up; ld = vq[i].ld; lv = vq[i].lv;
      #1 chk("tc", i, 32'(tc), 32'(vq[i].etc));
      @(posedge clk);
      #1 chk("out", i, 32'(out), 32'(vq[i].eout));
      chk("ovf", i, 32'(ovf), 32'(vq[i].eovf));
    end
    vq.delete();
  endtask
  initial begin
    int pulses;
    act = 1'b1; up = 1'b0;
    #2;
    chk("rst_out", 0, 32'(out), 0);
    chk("rst_ovf", 0, 32'(ovf), 0);
    chk("rst_tc", 0, 32'(tc), 1);
    @(negedge clk);
    act = 1'b0; up = 1'b1; reset = 1'b1;
    for (int k = 1; k <= 17; k++)
      add(1, 1, 0, 0, ((k - 1) % 10) == 9, 4'(k % 10), k >= 10);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 7, 1);
    run_q();
    @(negedge clk);
    act = 1'b0;
    #2 reset = 1'b0;
    #1 chk("async_out", 0, 32'(out), 0);
    chk("async_ovf", 0, 32'(ovf), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, k == 1, 4'(10 - k), 1);
`ifdef CPT_BIN_LOAD_EN
    add(1, 1, 1, 13, 0, 9, 0);
    add(1, 1, 1, 2, 0, 2, 0);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 9, 1);
    add(1, 0, 0, 0, 0, 8, 1);
`else
    add(1, 1, 1, 13, 0, 6, 1);
    add(1, 1, 1, 2, 0, 7, 1);
    add(1, 0, 0, 0, 0, 6, 1);
`endif
    run_q();
    @(negedge clk);
    act = 1'b0; ld = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("casc_init", 0, 32'({c1_out, c0_out}), 0);
    pulses = 0;
    cact = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      #1 if (c1_tc) pulses++;
      @(posedge clk);
      #1 chk("casc", k, 32'({c1_out, c0_out}), 32'({4'((k / 10) % 10), 4'(k % 10)}));
      @(negedge clk);
    end
    cact = 1'b0;
    chk("casc_tc_pulses", 0, 32'(pulses), 1);
    chk("casc_ovf1", 0, 32'(c1_ovf), 1);
    chk("casc_ovf0", 0, 32'(c0_ovf), 1);
    fact = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      #1 chk("full_tc", k, 32'(f_tc), 32'(((k - 1) % 8) == 7));
      @(posedge clk);
      #1 chk("full_out", k, 32'(f_out), 32'(k % 8));
      @(negedge clk);
    end
    fact = 1'b0;
    chk("full_ovf", 0, 32'(f_ovf), 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cpt_bin_mod.md
# cpt_bin_mod

Parametrised synchronous binary counter, successor to the fixed 8-bit ripple counter in the `compteur` library. It counts up or down within a configurable modulus, with an enable, an optional parallel load, a terminal-count output for cascading and a sticky wrap flag. All flops share one clock, so any width is glitch-free, and stages chain by feeding one instance's `tc` into the next instance's `activate`.

## Interface
- `WIDTH`, 8: counter width in bits; legal range is 1..32.
- `MODULO`, 2**WIDTH: count range is 0..MODULO-1; legal range is 2..2**WIDTH.

- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `activate`  input  1: count enable, sampled on `clk`.
- `up`  input  1: direction; 1 counts up, 0 counts down.
- `load`  input  1: synchronous parallel load (functional only with `CPT_BIN_LOAD_EN`).
- `load_val`  input  WIDTH: value loaded by `load`.
- `out`  output  WIDTH: registered count value.
- `tc`  output  1: combinational terminal count, for cascading.
- `ovf`  output  1: registered sticky wrap flag.

## Operation
- Next-state priority on each rising `clk` edge, highest first: load, then count, then hold.
- **Load** (`load`=1):
  - `out` takes `load_val`.
  - If `load_val` > MODULO-1, `out` takes MODULO-1 (clamped).
  - `ovf` clears to 0.
  - `activate` is ignored in that cycle.
- **Count up** (`activate`=1, `up`=1):
  - `out` increments by 1.
  - From MODULO-1 it wraps to 0 and sets `ovf`.
- **Count down** (`activate`=1, `up`=0):
  - `out` decrements by 1.
  - From 0 it wraps to MODULO-1 and sets `ovf`.
- **Hold** (`activate`=0 and no load): `out` and `ovf` keep their values.
- `tc` = `activate` AND ((`up` AND `out`==MODULO-1) OR (NOT `up` AND `out`==0)).
  - `tc` is high exactly in the cycle whose edge causes a wrap.
  - With `load`=1, `tc` is forced to 0.
- `ovf` only sets on a wrap. It clears only on load or reset.
- Arithmetic:
  - `out` never holds a value ≥ MODULO.
  - When MODULO=2**WIDTH, wrap is the natural modular overflow.
- Changing `up` takes effect on the next counting edge; there is no hysteresis or pipeline.
- Cascade: stage k+1 `activate` = stage k `tc`, with a common `clk` and `reset`.
  - The N-stage chain counts in base MODULO.
  - `tc` ripples combinationally, so the chain depth sets the maximum clock rate.

## Timing
- Reset:
  - While `reset`=0, `out`=0 and `ovf`=0 immediately, independent of `clk`.
  - `tc` then follows its equation; with `out`=0 it is high if `activate`=1 and `up`=0.
- Reset deassertion is used synchronously by the surrounding design. The first rising edge with `reset`=1 can already count or load.
- Reset asserted mid-count aborts the count. No partial update is retained.
- Latency:
  - `activate`, `load` and `up` sampled at edge n are visible on `out` and `ovf` after edge n.
  - `tc` is combinational from `activate`, `up`, `load` and `out`, with zero cycles of latency.
- The count rate is one step per enabled cycle. There are no dead cycles at wrap.

## Configuration
- Macro `CPT_BIN_LOAD_EN`.
- Defined: load behaves as in Operation.
- Undefined:
  - `load` and `load_val` remain as ports but are ignored.
  - There is no load logic.
  - `ovf` clears only on reset.
  - `tc` does not depend on `load`.

## Test plan
All scenarios use WIDTH=4 and MODULO=10 unless noted.
- Reset then up-count: hold `reset`=0 and check `out`=0, `ovf`=0. Release, set `activate`=1, `up`=1, run 12 edges. Expect `out` = 1..9, 0, 1, 2, with `tc`=1 only while `out`=9 and `ovf`=1 from the edge where `out` becomes 0.
- Down-count wrap: load 2 (`CPT_BIN_LOAD_EN` defined), set `up`=0, run 4 edges. Expect `out` = 1, 0, 9, 8, with `tc`=1 while `out`=0 and `ovf` set after the 9.
- Load priority and clamp: at `out`=5, drive `load`=1, `load_val`=13, `activate`=1. Expect `out`=9, `ovf`=0, `tc`=0 in that cycle. Without the macro, `out`=6.
- Hold and async reset: `activate`=0 for 3 edges keeps `out`=7. Pull `reset` low between edges: `out`=0 and `ovf`=0 before the next edge.
- Cascade: two instances with WIDTH=4, MODULO=10, up-counting, run 100 edges from 0. Expect stage values (tens, units) to go 0,0 … 9,9 … back to 0,0. Stage-1 `tc` pulses once; stage-1 `ovf`=1.
- Full-width: WIDTH=3, MODULO=8, run up-count 9 edges. Expect `out` = 1..7, 0, 1, with `tc` at 7.
